nic_interface: RTL and testbench

- Network interface controller on the pipeline's NIC port; the responder side of the processor's nicEn/nicEnWr/adder_nic load/store protocol.
- Provides one 64-bit input channel buffer (router to processor) and one 64-bit output channel buffer (processor to router), each with a full flag.
- The processor polls the full flags through status registers.
- Single-entry buffers, valid/ready handshake on the router side.

---
 rtl/nic_interface_pkg.sv | 11 +
 rtl/nic_interface_channel_buffer.sv | 40 ++++
 rtl/nic_interface.sv | 81 ++++++++
 tb/tb_nic_interface.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/nic_interface_pkg.sv
// Shared constants for the NIC port: register-select encodings and default data width.
package nic_interface_pkg;

  localparam int NIC_DATA_WIDTH = 64;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_interface_channel_buffer.sv
// One-entry channel buffer with full flag; a pop of a full entry wins over any push,
// and a push into a full entry is dropped. Contents survive a pop.
module nic_channel_buffer
  import nic_interface_pkg::*;
#(
  parameter int DATA_WIDTH = NIC_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_pop;
  logic                  w_push;

  assign w_pop  = i_pop & r_full;
  assign w_push = i_push & ~r_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (w_pop) begin
      r_full <= 1'b0;
    end else if (w_push) begin
      r_full <= 1'b1;
      r_data <= i_push_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/nic_interface.sv
// NIC responder on the processor load/store port: one inbound and one outbound
// single-entry packet buffer, with status registers the processor polls.
module nic_interface
  import nic_interface_pkg::*;
#(
  parameter int DATA_WIDTH     = NIC_DATA_WIDTH,
  parameter int NIC_ADDR_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      nicEn,
  input  logic                      nicEnWr,
  input  logic [NIC_ADDR_WIDTH-1:0] adder_nic,
  input  logic [DATA_WIDTH-1:0]     nic_dataIn,
  output logic [DATA_WIDTH-1:0]     nic_dataOut,
  input  logic                      net_si,
  output logic                      net_ri,
  input  logic [DATA_WIDTH-1:0]     net_di,
  output logic                      net_so,
  input  logic                      net_ro,
  output logic [DATA_WIDTH-1:0]     net_do
);

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_in_full;
  logic                  w_out_full;
  logic [DATA_WIDTH-1:0] w_in_data;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] r_data_out;

  assign w_rd = nicEn & ~nicEnWr;
  assign w_wr = nicEn & nicEnWr;

  nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_in_chan (
    .clk         (clk),
    .rst         (rst),
    .i_push      (net_si),
    .i_push_data (net_di),
    .i_pop       (w_rd && (adder_nic == NIC_IN_BUF)),
    .o_full      (w_in_full),
    .o_data      (w_in_data)
  );

  nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_out_chan (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_wr && (adder_nic == NIC_OUT_BUF)),
    .i_push_data (nic_dataIn),
    .i_pop       (net_ro),
    .o_full      (w_out_full),
    .o_data      (w_out_data)
  );

  // Read data is taken from pre-edge state, so a draining read returns the packet.
  always_comb begin
    w_rd_data = '0;
    case (adder_nic)
      NIC_IN_BUF:   w_rd_data = w_in_data;
      NIC_IN_STAT:  w_rd_data = {{(DATA_WIDTH-1){1'b0}}, w_in_full};
      NIC_OUT_BUF:  w_rd_data = w_out_data;
      NIC_OUT_STAT: w_rd_data = {{(DATA_WIDTH-1){1'b0}}, w_out_full};
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (w_rd) begin
      r_data_out <= w_rd_data;
    end
  end

  assign nic_dataOut = r_data_out;
  assign net_ri      = ~w_in_full;
  assign net_so      = w_out_full;
  assign net_do      = w_out_data;

endmodule

// File: tb/tb_nic_interface.sv
// Bench for nic_interface: directed scenarios plus randomized traffic against a
// behavioural model of the two mailboxes and the read-data register.
module tb_nic_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        nicEn;
  logic        nicEnWr;
  logic [1:0]  adder_nic;
  logic [63:0] nic_dataIn;
  logic [63:0] nic_dataOut;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [63:0] m_in_pkt, m_out_pkt, m_rdata;
  bit          m_in_has, m_out_has;

  always #5 clk = ~clk;

  nic_interface dut (
    .clk         (clk),
    .rst         (rst),
    .nicEn       (nicEn),
    .nicEnWr     (nicEnWr),
    .adder_nic   (adder_nic),
    .nic_dataIn  (nic_dataIn),
    .nic_dataOut (nic_dataOut),
    .net_si      (net_si),
    .net_ri      (net_ri),
    .net_di      (net_di),
    .net_so      (net_so),
    .net_ro      (net_ro),
    .net_do      (net_do)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_in_pkt = 64'd0; m_out_pkt = 64'd0; m_rdata = 64'd0;
    m_in_has = 0; m_out_has = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"}, nic_dataOut, m_rdata);
    check({tag, ".ri"},   {63'd0, net_ri}, {63'd0, !m_in_has});
    check({tag, ".so"},   {63'd0, net_so}, {63'd0, m_out_has});
    check({tag, ".do"},   net_do, m_out_pkt);
  endtask

  // One clock of stimulus; the model applies the mailbox rules to the pre-edge state.
  task automatic cycle(input string tag, input bit en, input bit wr, input logic [1:0] a,
                       input logic [63:0] din, input bit si, input logic [63:0] di, input bit ro);
    bit          rd_in, wr_out, take_in, give_out;
    logic [63:0] view;
    nicEn = en; nicEnWr = wr; adder_nic = a; nic_dataIn = din;
    net_si = si; net_di = di; net_ro = ro;
    view     = (a == 2'd0) ? m_in_pkt : (a == 2'd1) ? 64'(m_in_has) :
               (a == 2'd2) ? m_out_pkt : 64'(m_out_has);
    rd_in    = en && !wr && a == 2'd0 && m_in_has;
    take_in  = si && !m_in_has;
    give_out = ro && m_out_has;
    wr_out   = en && wr && a == 2'd2 && !m_out_has;
    @(posedge clk);
    if (en && !wr) m_rdata = view;
    if (rd_in) m_in_has = 0;
    if (take_in) begin m_in_has = 1; m_in_pkt = di; end
    if (give_out) m_out_has = 0;
    if (wr_out) begin m_out_has = 1; m_out_pkt = din; end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 2'd0, 64'd0, 0, 64'd0, 0);
  endtask

  task automatic mid_reset(input string tag);
    nicEn = 0; nicEnWr = 0; net_si = 0; net_ro = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check({tag, ".ri"},   {63'd0, net_ri}, 64'd1);
    check({tag, ".so"},   {63'd0, net_so}, 64'd0);
    check({tag, ".dout"}, nic_dataOut, 64'd0);
    check({tag, ".do"},   net_do, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; nicEn = 0; nicEnWr = 0; adder_nic = 2'd0; nic_dataIn = 64'd0;
    net_si = 0; net_di = 64'd0; net_ro = 0;
    model_reset();
    @(posedge clk); #1;
    mid_reset("reset");
    cycle("rd_in_stat0", 1, 0, 2'd1, 64'd0, 0, 64'd0, 0);
    check("in_stat_zero", nic_dataOut, 64'd0);
    cycle("rd_out_stat0", 1, 0, 2'd3, 64'd0, 0, 64'd0, 0);
    check("out_stat_zero", nic_dataOut, 64'd0);

    // Inbound packet and backpressure
    cycle("in_push", 0, 0, 2'd0, 64'd0, 1, 64'hDEAD_BEEF_0000_0001, 0);
    check("ri_low_after_push", {63'd0, net_ri}, 64'd0);
    cycle("in_stat1", 1, 0, 2'd1, 64'd0, 1, 64'h5, 0);
    check("in_stat_one", nic_dataOut, 64'd1);
    cycle("in_bp", 0, 0, 2'd0, 64'd0, 1, 64'h5, 0);
    check("ri_held_low", {63'd0, net_ri}, 64'd0);
    cycle("in_read", 1, 0, 2'd0, 64'd0, 1, 64'h5, 0);
    check("in_read_data", nic_dataOut, 64'hDEAD_BEEF_0000_0001);
    check("ri_after_drain", {63'd0, net_ri}, 64'd1);
    cycle("in_accept_next", 0, 0, 2'd0, 64'd0, 1, 64'h5, 0);
    cycle("in_read2", 1, 0, 2'd0, 64'd0, 0, 64'd0, 0);
    check("in_read2_data", nic_dataOut, 64'h5);
    cycle("in_stat_after", 1, 0, 2'd1, 64'd0, 0, 64'd0, 0);
    check("in_stat_cleared", nic_dataOut, 64'd0);
    cycle("in_stale", 1, 0, 2'd0, 64'd0, 0, 64'd0, 0);
    check("in_stale_data", nic_dataOut, 64'h5);

    // Outbound packet, drop-on-full, same-cycle drain
    cycle("out_wr", 1, 1, 2'd2, 64'h1234, 0, 64'd0, 0);
    check("so_set", {63'd0, net_so}, 64'd1);
    check("do_val", net_do, 64'h1234);
    cycle("out_stat", 1, 0, 2'd3, 64'd0, 0, 64'd0, 0);
    check("out_stat_one", nic_dataOut, 64'd1);
    cycle("out_drop", 1, 1, 2'd2, 64'hAAAA, 0, 64'd0, 0);
    check("do_kept", net_do, 64'h1234);
    cycle("out_drain_wr", 1, 1, 2'd2, 64'hBBBB, 0, 64'd0, 1);
    check("so_cleared", {63'd0, net_so}, 64'd0);
    check("do_retained", net_do, 64'h1234);
    cycle("out_buf_rd", 1, 0, 2'd2, 64'd0, 0, 64'd0, 0);
    check("out_buf_data", nic_dataOut, 64'h1234);

    // Ignored accesses
    cycle("wr00", 1, 1, 2'd0, 64'hFFFF, 0, 64'd0, 0);
    cycle("wr01", 1, 1, 2'd1, 64'hFFFF, 0, 64'd0, 0);
    cycle("wr11", 1, 1, 2'd3, 64'hFFFF, 0, 64'd0, 0);
    cycle("en0",  0, 1, 2'd2, 64'hFFFF, 0, 64'd0, 0);
    check("en0_no_write", {63'd0, net_so}, 64'd0);
    check("dout_held", nic_dataOut, 64'h1234);
    cycle("in_stat_ign", 1, 0, 2'd1, 64'd0, 0, 64'd0, 0);
    check("in_stat_ign_val", nic_dataOut, 64'd0);

    // Reset with both buffers occupied
    cycle("fill_in", 0, 0, 2'd0, 64'd0, 1, 64'h77, 0);
    cycle("fill_out", 1, 1, 2'd2, 64'h88, 0, 64'd0, 0);
    mid_reset("reset2");
    idle("post_reset");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle("rand", ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
            2'($urandom_range(0, 3)), {$urandom, $urandom},
            ($urandom_range(0, 4) < 2), {$urandom, $urandom},
            ($urandom_range(0, 4) < 2));
      if (i == 1500) mid_reset("reset_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
